cart_bus_initiator: RTL and testbench

// - Master-side sequencer for the cartridge slot bus; issues cycles that the cart responder decodes.
// - Converts a simple REQ/ACK word/byte request into timed VA/AS_N/CAS0_N/CAS2_N/LWR_N/UWR_N/CE0_N/ASEL_N/TIME_N cycles.
// - Waits for DTACK_N or a fixed wait count, returns read data, and flags timeouts.
// - Sits between the system-side bus arbiter and the cart slot.

---
 rtl/cart_bus_pkg.sv | 22 ++
 rtl/cart_bus_initiator_if.sv | 35 +++
 rtl/cart_region_decode.sv | 44 ++++
 rtl/cart_bus_initiator.sv | 161 ++++++++++++++++
 tb/tb_cart_bus_initiator.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cart_bus_pkg.sv
// Shared types and address constants for the cartridge slot bus initiator.
package cart_bus_pkg;

  typedef enum logic [2:0] {
    R_CE0,
    R_ASEL,
    R_EXT,
    R_TIME,
    R_UNMAP
  } region_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [15:0] TIME_BASE = 16'hA130;
  localparam logic [1:0]  EXT_BASE  = 2'b10;

endpackage

// File: rtl/cart_bus_initiator_if.sv
// System request side and cart slot side of the initiator, bundled as one interface.
interface cart_bus_initiator_if;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [23:1] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;
  logic [23:1] va;
  logic [15:0] vdo;
  logic [15:0] vdi;
  logic        as_n;
  logic        cas0_n;
  logic        cas2_n;
  logic        lwr_n;
  logic        uwr_n;
  logic        ce0_n;
  logic        asel_n;
  logic        time_n;
  logic        dtack_n;

  modport master (
    input  req, we, be, addr, wdata, vdi, dtack_n,
    output rdata, ack, err, va, vdo,
    output as_n, cas0_n, cas2_n, lwr_n, uwr_n, ce0_n, asel_n, time_n
  );

  modport slave (
    output req, we, be, addr, wdata, vdi, dtack_n,
    input  rdata, ack, err, va, vdo,
    input  as_n, cas0_n, cas2_n, lwr_n, uwr_n, ce0_n, asel_n, time_n
  );
endinterface

// File: rtl/cart_region_decode.sv
// Address region decode: select lines (active low) and the strobe wait limit per region.
module cart_region_decode
  import cart_bus_pkg::*;
#(
  parameter int ROM_WAIT      = 3,
  parameter int TIME_WAIT     = 2,
  parameter int DTACK_TIMEOUT = 64,
  parameter int CNT_W         = 7
) (
  input  logic [23:8]      va_hi,
  output region_t          region,
  output logic             ce0_n,
  output logic             asel_n,
  output logic             time_n,
  output logic [CNT_W-1:0] limit
);

  always_comb begin
    region = R_UNMAP;
    ce0_n  = 1'b1;
    asel_n = 1'b1;
    time_n = 1'b1;
    limit  = CNT_W'(DTACK_TIMEOUT);
    // TIME sits inside the EXT range, so it is tested first
    if (va_hi == TIME_BASE) begin
      region = R_TIME;
      time_n = 1'b0;
      limit  = CNT_W'(TIME_WAIT);
    end else if (va_hi[23:22] == 2'b00) begin
      region = R_CE0;
      ce0_n  = 1'b0;
      asel_n = 1'b0;
      limit  = CNT_W'(ROM_WAIT);
    end else if (va_hi[23:22] == 2'b01) begin
      region = R_ASEL;
      asel_n = 1'b0;
      limit  = CNT_W'(ROM_WAIT);
    end else if (va_hi[23:22] == EXT_BASE) begin
      region = R_EXT;
      limit  = CNT_W'(DTACK_TIMEOUT);
    end
  end

endmodule

// File: rtl/cart_bus_initiator.sv
// Cartridge slot bus master: turns REQ/ACK word/byte requests into timed cart strobe cycles.
module cart_bus_initiator
  import cart_bus_pkg::*;
#(
  parameter int ROM_WAIT      = 3,
  parameter int TIME_WAIT     = 2,
  parameter int DTACK_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  cart_bus_initiator_if.master bus
);

  localparam int CNT_W = $clog2(DTACK_TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  limit;
  logic [23:1]       va;
  logic [15:0]       vdo;
  logic [15:0]       rdata;
  logic              we_q;
  logic [1:0]        be_q;
  logic              err_q;
  region_t           region;
  logic              dec_ce0_n;
  logic              dec_asel_n;
  logic              dec_time_n;
  logic              strobe_done;
  logic              timeout;
  logic              as_n;
  logic              cas0_n;
  logic              cas2_n;
  logic              lwr_n;
  logic              uwr_n;
  logic              ce0_n;
  logic              asel_n;
  logic              time_n;

  cart_region_decode #(
    .ROM_WAIT      (ROM_WAIT),
    .TIME_WAIT     (TIME_WAIT),
    .DTACK_TIMEOUT (DTACK_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_decode (
    .va_hi  (va[23:8]),
    .region (region),
    .ce0_n  (dec_ce0_n),
    .asel_n (dec_asel_n),
    .time_n (dec_time_n),
    .limit  (limit)
  );

  assign cnt_inc     = cnt + 1'b1;
  // DTACK_N low on the final count cycle still completes without error
  assign strobe_done = !bus.dtack_n || (cnt_inc >= limit);
  assign timeout     = bus.dtack_n && (region == R_EXT) && (cnt_inc >= limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.req) state_next = S_SETUP;
      S_SETUP:  state_next = (region == R_UNMAP) ? S_HOLD : S_STROBE;
      S_STROBE: if (strobe_done) state_next = S_HOLD;
      S_HOLD:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      va    <= '0;
      vdo   <= '0;
      rdata <= '0;
      we_q  <= 1'b0;
      be_q  <= 2'b00;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            va    <= bus.addr;
            vdo   <= bus.wdata;
            we_q  <= bus.we;
            be_q  <= bus.be;
            err_q <= 1'b0;
            cnt   <= '0;
          end
        end
        S_SETUP: begin
          cnt <= '0;
          if (region == R_UNMAP) begin
            rdata <= '0;
            err_q <= 1'b1;
          end
        end
        S_STROBE: begin
          cnt <= cnt_inc;
          if (strobe_done) begin
            rdata <= we_q ? 16'h0000 : bus.vdi;
            err_q <= timeout;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so reset releases them without a clock
  always_comb begin
    as_n   = 1'b1;
    cas0_n = 1'b1;
    cas2_n = 1'b1;
    lwr_n  = 1'b1;
    uwr_n  = 1'b1;
    ce0_n  = 1'b1;
    asel_n = 1'b1;
    time_n = 1'b1;
    if (state == S_SETUP || state == S_STROBE) begin
      ce0_n  = dec_ce0_n;
      asel_n = dec_asel_n;
      time_n = dec_time_n;
    end
    if (state == S_STROBE) begin
      as_n = 1'b0;
      if (we_q) begin
        uwr_n = ~be_q[1];
        lwr_n = ~be_q[0];
      end else begin
        cas0_n = 1'b0;
        cas2_n = (region != R_ASEL);
      end
    end
  end

  assign bus.as_n   = as_n;
  assign bus.cas0_n = cas0_n;
  assign bus.cas2_n = cas2_n;
  assign bus.lwr_n  = lwr_n;
  assign bus.uwr_n  = uwr_n;
  assign bus.ce0_n  = ce0_n;
  assign bus.asel_n = asel_n;
  assign bus.time_n = time_n;
  assign bus.va     = va;
  assign bus.vdo    = vdo;
  assign bus.rdata  = rdata;
  assign bus.ack    = (state == S_HOLD);
  assign bus.err    = (state == S_HOLD) && err_q;

endmodule

// File: tb/tb_cart_bus_initiator.sv
// Directed bench for the cartridge slot bus initiator.
module tb_cart_bus_initiator;

  typedef struct {
    int          ack_at;
    int          as_low;
    int          cas0_low;
    int          cas2_low;
    int          lwr_low;
    int          uwr_low;
    logic [3:0]  setup_sel;
    logic [15:0] rdata;
    logic [15:0] vdo;
    logic [23:1] va;
    logic        err;
  } obs_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  cart_bus_initiator_if bus ();

  cart_bus_initiator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // setup_sel = {ce0_n, asel_n, time_n, as_n} in the first cycle after accept
  task automatic do_access(input logic w, input logic [1:0] b, input logic [23:1] a,
                           input logic [15:0] d, input logic [15:0] vdi_val,
                           input int dtack_at, input int budget, output obs_t o);
    int n;
    int strb;
    o = '{default: 0};
    n = 0;
    strb = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.be = b; bus.addr = a; bus.wdata = d;
    bus.vdi = vdi_val; bus.dtack_n = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    while (o.ack_at == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (n == 1) o.setup_sel = {bus.ce0_n, bus.asel_n, bus.time_n, bus.as_n};
      if (!bus.as_n) begin
        strb++;
        o.as_low++;
        if (strb == dtack_at) bus.dtack_n = 1'b0;
      end
      if (!bus.cas0_n) o.cas0_low++;
      if (!bus.cas2_n) o.cas2_low++;
      if (!bus.lwr_n)  o.lwr_low++;
      if (!bus.uwr_n)  o.uwr_low++;
      if (bus.ack) begin
        o.ack_at = n;
        o.rdata  = bus.rdata;
        o.err    = bus.err;
        o.vdo    = bus.vdo;
        o.va     = bus.va;
        bus.dtack_n = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.be = 2'b00; bus.addr = '0; bus.wdata = '0;
    bus.vdi = '0; bus.dtack_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.as_n, bus.cas0_n, bus.cas2_n, bus.lwr_n, bus.uwr_n, bus.ce0_n, bus.asel_n, bus.time_n} !== 8'hFF) begin
      fails++; $display("FAIL reset_strobes got %b expected 11111111",
        {bus.as_n, bus.cas0_n, bus.cas2_n, bus.lwr_n, bus.uwr_n, bus.ce0_n, bus.asel_n, bus.time_n});
    end
    checks++;
    if ({bus.ack, bus.err} !== 2'b00) begin
      fails++; $display("FAIL reset_ack_err got %b expected 00", {bus.ack, bus.err});
    end
    checks++;
    if ({bus.rdata, bus.vdo, bus.va} !== 55'd0) begin
      fails++; $display("FAIL reset_data got rdata=%h vdo=%h va=%h expected 0", bus.rdata, bus.vdo, bus.va);
    end
    rst = 1'b0;
  endtask

  task automatic test_rom_read();
    obs_t o;
    do_access(1'b0, 2'b00, 23'h000080, 16'h0000, 16'h1234, 0, 20, o);
    checks++; if (o.setup_sel !== 4'b0011) begin fails++; $display("FAIL rom_setup_sel got %b expected 0011", o.setup_sel); end
    checks++; if (o.cas0_low !== 3) begin fails++; $display("FAIL rom_cas0_low got %0d expected 3", o.cas0_low); end
    checks++; if (o.cas2_low !== 0) begin fails++; $display("FAIL rom_cas2_low got %0d expected 0", o.cas2_low); end
    checks++; if (o.ack_at !== 5) begin fails++; $display("FAIL rom_ack_at got %0d expected 5", o.ack_at); end
    checks++; if (o.rdata !== 16'h1234) begin fails++; $display("FAIL rom_rdata got %h expected 1234", o.rdata); end
    checks++; if (o.err !== 1'b0) begin fails++; $display("FAIL rom_err got %b expected 0", o.err); end
  endtask

  task automatic test_time_write();
    obs_t o;
    do_access(1'b1, 2'b01, 23'h509800, 16'h0001, 16'hFFFF, 0, 20, o);
    checks++; if (o.setup_sel !== 4'b1101) begin fails++; $display("FAIL time_setup_sel got %b expected 1101", o.setup_sel); end
    checks++; if (o.lwr_low !== 2) begin fails++; $display("FAIL time_lwr_low got %0d expected 2", o.lwr_low); end
    checks++; if (o.uwr_low !== 0) begin fails++; $display("FAIL time_uwr_low got %0d expected 0", o.uwr_low); end
    checks++; if (o.cas0_low !== 0) begin fails++; $display("FAIL time_cas0_low got %0d expected 0", o.cas0_low); end
    checks++; if (o.vdo !== 16'h0001) begin fails++; $display("FAIL time_vdo got %h expected 0001", o.vdo); end
    checks++; if (o.va !== 23'h509800) begin fails++; $display("FAIL time_va got %h expected 509800", o.va); end
    checks++; if ({o.ack_at, o.err} !== {32'd4, 1'b0}) begin fails++; $display("FAIL time_ack got at=%0d err=%b expected at=4 err=0", o.ack_at, o.err); end
  endtask

  task automatic test_asel_read();
    obs_t o;
    do_access(1'b0, 2'b00, 23'h200000, 16'h0000, 16'h5A5A, 1, 20, o);
    checks++; if (o.setup_sel !== 4'b1011) begin fails++; $display("FAIL asel_setup_sel got %b expected 1011", o.setup_sel); end
    checks++; if (o.cas2_low !== 1) begin fails++; $display("FAIL asel_cas2_low got %0d expected 1", o.cas2_low); end
    checks++; if (o.ack_at !== 3) begin fails++; $display("FAIL asel_ack_at got %0d expected 3", o.ack_at); end
    checks++; if (o.rdata !== 16'h5A5A) begin fails++; $display("FAIL asel_rdata got %h expected 5a5a", o.rdata); end
  endtask

  task automatic test_ext_dtack();
    obs_t o;
    do_access(1'b0, 2'b00, 23'h420000, 16'h0000, 16'hBEEF, 5, 100, o);
    checks++; if (o.setup_sel !== 4'b1111) begin fails++; $display("FAIL ext_setup_sel got %b expected 1111", o.setup_sel); end
    checks++; if (o.cas0_low !== 5) begin fails++; $display("FAIL ext_cas0_low got %0d expected 5", o.cas0_low); end
    checks++; if (o.cas2_low !== 0) begin fails++; $display("FAIL ext_cas2_low got %0d expected 0", o.cas2_low); end
    checks++; if (o.ack_at !== 7) begin fails++; $display("FAIL ext_ack_at got %0d expected 7", o.ack_at); end
    checks++; if ({o.rdata, o.err} !== {16'hBEEF, 1'b0}) begin fails++; $display("FAIL ext_rdata got %h err=%b expected beef err=0", o.rdata, o.err); end
  endtask

  task automatic test_ext_timeout();
    obs_t o;
    do_access(1'b0, 2'b00, 23'h420000, 16'h0000, 16'hCAFE, 0, 100, o);
    checks++; if (o.as_low !== 64) begin fails++; $display("FAIL timeout_as_low got %0d expected 64", o.as_low); end
    checks++; if (o.ack_at !== 66) begin fails++; $display("FAIL timeout_ack_at got %0d expected 66", o.ack_at); end
    checks++; if (o.err !== 1'b1) begin fails++; $display("FAIL timeout_err got %b expected 1", o.err); end
    do_access(1'b0, 2'b00, 23'h420000, 16'h0000, 16'h7777, 64, 100, o);
    checks++; if ({o.ack_at, o.err} !== {32'd66, 1'b0}) begin fails++; $display("FAIL last_cycle_dtack got at=%0d err=%b expected at=66 err=0", o.ack_at, o.err); end
    checks++; if (o.rdata !== 16'h7777) begin fails++; $display("FAIL last_cycle_rdata got %h expected 7777", o.rdata); end
  endtask

  task automatic test_back_to_back();
    int win_idx = 0;
    int win1 = 0;
    int win2 = 0;
    int gap = 0;
    int acks = 0;
    int n = 0;
    logic prev = 1'b1;
    logic [23:1] va2 = '0;
    logic [15:0] vdo2 = '0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.be = 2'b01; bus.addr = 23'h100000; bus.wdata = 16'hAAAA;
    bus.dtack_n = 1'b1;
    while (acks < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (!bus.lwr_n && prev) win_idx++;
      if (!bus.lwr_n && win_idx == 1) win1++;
      if (!bus.lwr_n && win_idx == 2) begin win2++; va2 = bus.va; vdo2 = bus.vdo; end
      if (bus.lwr_n && win_idx == 1) gap++;
      prev = bus.lwr_n;
      if (bus.ack) begin
        acks++;
        if (acks == 1) begin bus.addr = 23'h100001; bus.wdata = 16'h5555; end
        else bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    checks++; if (acks !== 2) begin fails++; $display("FAIL b2b_acks got %0d expected 2", acks); end
    checks++; if ({win1, win2} !== {32'd3, 32'd3}) begin fails++; $display("FAIL b2b_windows got %0d/%0d expected 3/3", win1, win2); end
    checks++; if (gap < 2) begin fails++; $display("FAIL b2b_gap got %0d expected >=2", gap); end
    checks++; if ({va2, vdo2} !== {23'h100001, 16'h5555}) begin fails++; $display("FAIL b2b_second got va=%h vdo=%h expected 100001/5555", va2, vdo2); end
  endtask

  task automatic test_reset_mid_cycle();
    obs_t o;
    int n = 0;
    int acks = 0;
    logic [7:0] strobes;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.be = 2'b11; bus.addr = 23'h000000; bus.wdata = 16'h1111;
    bus.dtack_n = 1'b1;
    while (bus.as_n && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus.as_n !== 1'b0) begin fails++; $display("FAIL rstmid_enter got as_n=%b expected 0", bus.as_n); end
    #2 rst = 1'b1;
    #1 strobes = {bus.as_n, bus.cas0_n, bus.cas2_n, bus.lwr_n, bus.uwr_n, bus.ce0_n, bus.asel_n, bus.time_n};
    checks++; if (strobes !== 8'hFF) begin fails++; $display("FAIL rstmid_strobes got %b expected 11111111", strobes); end
    bus.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.ack) acks++; end
    checks++; if (acks !== 0) begin fails++; $display("FAIL rstmid_no_ack got %0d acks expected 0", acks); end
    do_access(1'b0, 2'b00, 23'h000080, 16'h0000, 16'h4321, 0, 20, o);
    checks++; if ({o.ack_at, o.rdata, o.err} !== {32'd5, 16'h4321, 1'b0}) begin
      fails++; $display("FAIL rstmid_after got at=%0d rdata=%h err=%b expected at=5 rdata=4321 err=0", o.ack_at, o.rdata, o.err);
    end
  endtask

  task automatic test_unmapped();
    obs_t o;
    do_access(1'b0, 2'b00, 23'h600000, 16'h0000, 16'hFFFF, 1, 20, o);
    checks++; if (o.as_low !== 0) begin fails++; $display("FAIL unmap_as_low got %0d expected 0", o.as_low); end
    checks++; if (o.setup_sel !== 4'b1111) begin fails++; $display("FAIL unmap_setup_sel got %b expected 1111", o.setup_sel); end
    checks++; if (o.ack_at !== 2) begin fails++; $display("FAIL unmap_ack_at got %0d expected 2", o.ack_at); end
    checks++; if ({o.err, o.rdata} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL unmap_err_rdata got err=%b rdata=%h expected err=1 rdata=0000", o.err, o.rdata); end
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_time_write();
    test_asel_read();
    test_ext_dtack();
    test_ext_timeout();
    test_back_to_back();
    test_reset_mid_cycle();
    test_unmapped();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
